// File: rtl/add_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_acc_pkg
// Purpose  : Shared types, defaults and width helper for add_accumulator.
// Revision : 1.0
// ============================================================================
package add_acc_pkg;

    localparam int DEF_N   = 4;
    localparam int DEF_CNT = 4;
    localparam int DEF_CW  = 2;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int acc_w(input int n, input int cw);
        return n + cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_adder.sv
`default_nettype none
// ============================================================================
// Module   : acc_adder
// Purpose  : Unsigned W-bit combinational adder with carry-out.
// Revision : 1.0
// ============================================================================
module acc_adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign sum    = w_full[W-1:0];
    assign carry  = w_full[W];

endmodule
`default_nettype wire

// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : add_accumulator
// Purpose  : Sums CNT unsigned operands per frame and presents the result
//            with a sticky overflow flag under a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module add_accumulator
    import add_acc_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int CNT = DEF_CNT,
    parameter int CW  = DEF_CW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [acc_w(N, CW)-1:0]   out_sum,
    output logic                      out_ovf
);

    localparam int ACC_W = acc_w(N, CW);
    localparam int CNT_W = $clog2(CNT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CNT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    acc_adder #(
        .W (ACC_W)
    ) u_acc_adder (
        .a     (r_acc),
        .b     (ACC_W'(in_data)),
        .sum   (w_sum),
        .carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_state_nxt = ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        w_acc_nxt = w_sum;
                        w_ovf_nxt = r_ovf | w_carry;
                        // Wrap the count on the last operand so it never exceeds CNT-1.
                        if (r_cnt == C_CNT_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = HOLD;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = ACCUM;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_accumulator
// Purpose  : Self-checking bench; frame-total reference model plus directed
//            and randomized stimulus. Second instance covers CW=1 overflow.
// Revision : 1.0
// ============================================================================
module tb_add_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, out_ovf;
    logic [5:0] out_sum;

    logic       b_clear, b_in_valid, b_out_ready;
    logic [3:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_out_ovf;
    logic [4:0] b_out_sum;

    int checks   = 0;
    int failures = 0;

    // Model: running frame total; sum and overflow follow from plain arithmetic.
    int m_total = 0;
    int m_count = 0;
    bit m_hold  = 1'b0;

    always #5 clk = ~clk;

    add_accumulator #(.N(4), .CNT(4), .CW(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    add_accumulator #(.N(4), .CNT(4), .CW(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (b_clear),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_ovf   (b_out_ovf)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_hold));
        check({tag, ".in_ready"},  int'(in_ready),  int'(!m_hold));
        check({tag, ".out_sum"},   int'(out_sum),   m_total % 64);
        check({tag, ".out_ovf"},   int'(out_ovf),   int'(m_total >= 64));
    endtask

    task automatic model_reset();
        m_total = 0;
        m_count = 0;
        m_hold  = 1'b0;
    endtask

    task automatic cycle(input bit v, input int d, input bit r, input bit c, input string tag);
        in_valid  = v;
        in_data   = 4'(d);
        out_ready = r;
        clear     = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (m_hold) begin
            if (r) model_reset();
        end else if (v) begin
            m_total += d;
            m_count++;
            if (m_count == 4) m_hold = 1'b1;
        end
        #1;
        check_a(tag);
    endtask

    task automatic b_push(input int d);
        b_in_valid = 1'b1;
        b_in_data  = 4'(d);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_a("reset");
        rst_n = 1'b1;

        // Back-to-back frame with downstream always ready.
        cycle(1, 3, 1, 0, "f1_op0");
        cycle(1, 5, 1, 0, "f1_op1");
        cycle(1, 7, 1, 0, "f1_op2");
        cycle(1, 9, 1, 0, "f1_op3");
        check("f1_sum24", int'(out_sum), 24);
        cycle(0, 0, 1, 0, "f1_release");

        // in_valid toggling; only handshakes advance the frame.
        for (int i = 0; i < 8; i++)
            cycle(i[0] == 1'b0, 15, 0, 0, "f2_toggle");
        check("f2_sum60", int'(out_sum), 60);

        // Stall for 5 cycles with stray in_valid pulses.
        for (int i = 0; i < 5; i++)
            cycle(1, 4, 0, 0, "stall");
        cycle(1, 4, 1, 0, "stall_release");
        cycle(1, 2, 0, 0, "f3_op0");
        cycle(1, 2, 0, 0, "f3_op1");
        cycle(1, 2, 0, 0, "f3_op2");
        cycle(1, 2, 0, 0, "f3_op3");
        check("f3_sum8", int'(out_sum), 8);
        cycle(0, 0, 1, 0, "f3_release");

        // Abort after two operands, then a fresh frame.
        cycle(1, 9, 0, 0, "clr_op0");
        cycle(1, 9, 0, 0, "clr_op1");
        cycle(1, 9, 0, 1, "clr_abort");
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 0, 0, "f4_ones");
        check("f4_sum4", int'(out_sum), 4);

        // Reset during HOLD discards the pending result.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_a("rst_in_hold");
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rand");

        // CW=1 instance: 15+15+15+1 = 46 wraps to 14 with overflow.
        b_push(15);
        b_push(15);
        check("b_no_ovf_yet", int'(b_out_ovf), int'((15 + 15) >= 32));
        b_push(15);
        check("b_ovf_set", int'(b_out_ovf), int'((15 + 15 + 15) >= 32));
        b_push(1);
        check("b_out_valid", int'(b_out_valid), 1);
        check("b_out_sum", int'(b_out_sum), 46 % 32);
        check("b_out_ovf", int'(b_out_ovf), 1);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b_released", int'(b_in_ready), 1);
        check("b_ovf_cleared", int'(b_out_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter N, default 4: operand width in bits.
REQ-002 Parameter CNT, default 4: operands summed per frame, at least 2.
REQ-003 Parameter CW, default 2: accumulator guard bits; ACC_W = N + CW.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 clear  in  1  synchronous frame abort.
REQ-007 in_valid  in  1  upstream operand valid.
REQ-008 in_ready  out  1  block accepts an operand this cycle.
REQ-009 in_data  in  N  unsigned operand.
REQ-010 out_valid  out  1  frame result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  ACC_W  frame sum, modulo 2^ACC_W.
REQ-013 out_ovf  out  1  sticky flag: a carry was lost out of bit ACC_W-1 during the frame.

Function
REQ-014 The FSM SHALL have two states: ACCUM and HOLD.
REQ-015 in_ready SHALL be 1 exactly when the state is ACCUM; out_valid SHALL be 1 exactly when the state is HOLD.
REQ-016 An input handshake (in_valid & in_ready) SHALL register acc <= acc + zero-extended in_data and cnt <= cnt + 1.
REQ-017 When the handshake occurs with cnt == CNT-1, the state SHALL move to HOLD on that edge, so out_valid rises in the next cycle.
- Latency: 1 cycle from the last operand to the result.
REQ-018 In ACCUM with in_valid low, acc, cnt and out_ovf SHALL hold.
REQ-019 out_sum SHALL equal the acc register at all times and SHALL stay stable while in HOLD.
REQ-020 A carry out of bit ACC_W-1 on any accumulate SHALL set out_ovf; out_ovf SHALL stay set until the frame ends.
REQ-021 In HOLD with out_ready high, the block SHALL clear acc, cnt and out_ovf and return to ACCUM on that edge.
- in_ready is therefore 1 in the following cycle.
- There is no same-cycle pass-through of a new operand.
REQ-022 In HOLD with out_ready low, all state SHALL hold indefinitely, and in_valid SHALL be ignored.
REQ-023 clear high, in either state, SHALL force ACCUM with acc = 0, cnt = 0 and out_ovf = 0 on that edge.
- clear overrides any simultaneous input or output handshake.
- A result dropped by clear is lost.
REQ-024 cnt SHALL be ceil(log2(CNT)) bits wide and SHALL never exceed CNT-1.

Reset
REQ-025 While rst_n is low at a rising edge, the block SHALL set state = ACCUM, acc = 0, cnt = 0 and out_ovf = 0.
- Resulting outputs: in_ready = 1, out_valid = 0, out_sum = 0, out_ovf = 0.
REQ-026 Reset SHALL take priority over clear and over both handshakes.
REQ-027 Reset during a frame or during HOLD SHALL discard the partial or pending result with no output handshake.

Structure
REQ-028 A shared package add_acc_pkg SHALL hold:
- the state enum (ACCUM, HOLD);
- the ACC_W derivation function;
- the default parameter values.
REQ-029 The datapath adder SHALL be one sub-module, acc_adder.
- Function: ACC_W-bit unsigned combinational adder with carry-out.
- It is instantiated once; its carry-out drives the out_ovf set logic.
REQ-030 All outputs SHALL be driven from registers or from state decode only, with no combinational path from in_* to out_*.

Verification
REQ-031 With N=4, CNT=4, CW=2: operands 3, 5, 7, 9 back-to-back with out_ready high -> out_valid for exactly 1 cycle, out_sum = 24, out_ovf = 0, then in_ready = 1.
REQ-032 Same configuration, operands 15, 15, 15, 15 with in_valid toggling every other cycle -> out_sum = 60, out_ovf = 0, and cnt advances only on handshakes.
REQ-033 With CW=1 (ACC_W = 5), CNT=4: operands 15, 15, 15, 1 -> out_sum = 14 (46 mod 32), out_ovf = 1.
REQ-034 out_ready held low for 5 cycles after the result -> out_sum stays stable, in_ready = 0, and extra in_valid pulses are ignored; the next frame sums correctly after release.
REQ-035 clear asserted after 2 of 4 operands, then a fresh frame of 1, 1, 1, 1 -> out_sum = 4.
REQ-036 rst_n driven low for 1 cycle during HOLD -> next cycle out_valid = 0, in_ready = 1, out_sum = 0, out_ovf = 0.
